mio_mem_responder: RTL and testbench
====================================

Name: mio_mem_responder

Overview:
- Memory-side responder for the CPU memory/IO bus; the other end of the CPU's CPU_MIO / mem_w / RAMCtrl / MIO_ready handshake.
- Accepts one request at a time and inserts programmable wait states.
- Performs word, halfword or byte reads and writes on an internal little-endian word RAM.
- Returns read data with sign or zero extension, and pulses MIO_ready once per completed transaction.

Parameters:
- ADDR_WIDTH, 10, word-index bits; RAM depth is 2**ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 2, wait states between acceptance and response; 0 is legal.
- BASE_ADDR, 32'h0000_0000, byte address of RAM word 0.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- CPU_MIO  in  1  request valid from CPU.
- mem_w  in  1  1 = write, 0 = read; qualified by CPU_MIO.
- RAMCtrl  in  3  [1:0] size (00 word, 01 half, 10 byte, 11 treated as word); [2] 1 = zero-extend load, 0 = sign-extend load.
- addr  in  32  byte address.
- wdata  in  32  write data, right-aligned for half and byte.
- MIO_ready  out  1  one-cycle completion pulse.
- rdata  out  32  extended read data.

Behaviour:
- States: IDLE, WAIT, RESP. Reset forces IDLE, MIO_ready=0, rdata=0, wait counter=0. RAM contents are not cleared.
- IDLE: when CPU_MIO=1 at a rising edge, latch addr, wdata, mem_w and RAMCtrl.
  - WAIT_CYCLES>0: go to WAIT with counter=WAIT_CYCLES-1.
  - WAIT_CYCLES=0: go directly to RESP.
- WAIT: decrement the counter each cycle; move to RESP on the edge where counter==0. Inputs are ignored while in WAIT.
- RESP: MIO_ready=1 for exactly this cycle; next state is always IDLE.
  - A request still asserted in the cycle after RESP is accepted as a new transaction.
  - Holding CPU_MIO across a response therefore repeats the access.
- Latency: MIO_ready is high in cycle N+WAIT_CYCLES+1, where N is the acceptance cycle.
- Write commit: on the edge entering RESP, using byte enables.
  - Word address = (addr-BASE_ADDR)[ADDR_WIDTH+1:2].
  - Byte: wdata[7:0] written to lane addr[1:0]; lane k is bits 8k+7:8k.
  - Half: wdata[15:0] written to lanes {addr[1],0} and {addr[1],1}; addr[0] ignored.
  - Word: all four lanes written; addr[1:0] ignored.
- Read:
  - rdata is registered on the edge entering RESP.
  - rdata is valid while MIO_ready=1 and holds until the next read response.
  - Writes leave rdata unchanged.
  - Byte/half reads are selected by the same lane rules, then extended to 32 bits per RAMCtrl[2].
- Out-of-range addresses (without the optional feature): the word index wraps modulo depth.
- Reset mid-transaction: returns to IDLE; a pending write is discarded; no MIO_ready is issued.
- Reads of a word written in the immediately preceding transaction return the new data.

Optional Feature:
- Macro MIO_BUS_ERR_EN.
- Defined:
  - Adds output bus_err (1 bit, reset 0).
  - A request with addr < BASE_ADDR or addr >= BASE_ADDR + 4*2**ADDR_WIDTH still completes with normal timing.
  - Writes are dropped; reads return 0.
  - bus_err=1 in the same RESP cycle as MIO_ready.
- Undefined: no bus_err port; the index wraps modulo depth.

Test Plan:
- Word write then read, WAIT_CYCLES=2: write addr 0x10 wdata 0xDEADBEEF, read 0x10 RAMCtrl=000 -> MIO_ready pulses 3 cycles after each acceptance; rdata=0xDEADBEEF.
- Byte lanes: word 0x10 = 0x11223344; byte read 0x13 signed -> 0x00000011; byte write 0xF0 to 0x11 then signed byte read 0x11 -> 0xFFFFFFF0; unsigned -> 0x000000F0; word read -> 0x1122F044.
- Halfword: word 0x20 = 0x8001_7FFE; half read 0x22 signed -> 0xFFFF8001; unsigned -> 0x00008001; half read 0x21 -> 0x00007FFE (addr[0] ignored).
- Back-to-back requests: CPU_MIO held high for two requests with WAIT_CYCLES=0 -> MIO_ready high in alternate cycles; exactly one pulse per request.
- Reset in WAIT during a write of 0xA5A5A5A5 to 0x30 -> no MIO_ready; a later read of 0x30 returns the prior contents.
- MIO_BUS_ERR_EN defined, ADDR_WIDTH=10: read addr 0x1000 -> rdata=0, bus_err=1 with MIO_ready; write to 0x1000 leaves word 0 unchanged.

Source files
------------

// File: rtl/mio_mem_responder_if.sv
// CPU memory/IO bus bundle between the CPU (master) and the memory responder (slave).
// bus_err exists only when MIO_BUS_ERR_EN is defined.
interface mio_mem_responder_if;
    logic        CPU_MIO;
    logic        mem_w;
    logic [2:0]  RAMCtrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        MIO_ready;
    logic [31:0] rdata;
`ifdef MIO_BUS_ERR_EN
    logic        bus_err;
`endif

    modport master (
        output CPU_MIO, mem_w, RAMCtrl, addr, wdata,
        input  MIO_ready, rdata
`ifdef MIO_BUS_ERR_EN
        , input bus_err
`endif
    );

    modport slave (
        input  CPU_MIO, mem_w, RAMCtrl, addr, wdata,
        output MIO_ready, rdata
`ifdef MIO_BUS_ERR_EN
        , output bus_err
`endif
    );
endinterface

// File: rtl/mio_mem_responder.sv
// Memory-side responder: one request at a time, programmable wait states, byte/half/word RAM access.
// Optional macro MIO_BUS_ERR_EN: out-of-range requests flag bus_err instead of wrapping.
module mio_mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    mio_mem_responder_if.slave bus
);
    localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int unsigned WAIT_INIT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
`ifdef MIO_BUS_ERR_EN
    localparam logic [32:0] DEPTH_BYTES = 33'(DEPTH) << 2;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    accept;
    logic                    enter_resp;

    logic [31:0]             req_addr_q, req_wdata_q;
    logic                    req_we_q;
    logic [2:0]              req_ctrl_q;
    logic [31:0]             cur_addr, cur_wdata;
    logic                    cur_we;
    logic [2:0]              cur_ctrl;

    logic [31:0]             offset;
    logic [ADDR_WIDTH-1:0]   idx;
    logic                    in_range;
    logic [3:0]              be;
    logic [31:0]             wword, rd_word, rd_ext;
    logic [7:0]              lane_b;
    logic [15:0]             lane_h;

    logic [31:0]             mem [DEPTH];
    logic                    ready_q;
    logic [31:0]             rdata_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and wait counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.CPU_MIO) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_INIT);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_RESP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign enter_resp = (state_d == ST_RESP);

    // Request capture; with zero wait states the live bus feeds the commit directly
    always_ff @(posedge clk) begin
        if (accept) begin
            req_addr_q  <= bus.addr;
            req_wdata_q <= bus.wdata;
            req_we_q    <= bus.mem_w;
            req_ctrl_q  <= bus.RAMCtrl;
        end
    end

    assign cur_addr  = (state_q == ST_IDLE) ? bus.addr    : req_addr_q;
    assign cur_wdata = (state_q == ST_IDLE) ? bus.wdata   : req_wdata_q;
    assign cur_we    = (state_q == ST_IDLE) ? bus.mem_w   : req_we_q;
    assign cur_ctrl  = (state_q == ST_IDLE) ? bus.RAMCtrl : req_ctrl_q;

    assign offset = cur_addr - BASE_ADDR;
    assign idx    = offset[ADDR_WIDTH+1:2];
`ifdef MIO_BUS_ERR_EN
    assign in_range = (cur_addr >= BASE_ADDR) && ({1'b0, offset} < DEPTH_BYTES);
`else
    assign in_range = 1'b1;
`endif

    logic unused_offset_bits;
    assign unused_offset_bits = ^{offset[31:ADDR_WIDTH+2], offset[1:0]};

    // Lane enables and replicated write data
    always_comb begin
        case (cur_ctrl[1:0])
            2'b01: begin
                be    = cur_addr[1] ? 4'b1100 : 4'b0011;
                wword = {2{cur_wdata[15:0]}};
            end
            2'b10: begin
                be    = 4'(4'b0001 << cur_addr[1:0]);
                wword = {4{cur_wdata[7:0]}};
            end
            default: begin
                be    = 4'b1111;
                wword = cur_wdata;
            end
        endcase
    end

    // Lane select and sign/zero extension of the read word
    always_comb begin
        rd_word = mem[idx];
        lane_b  = rd_word[{cur_addr[1:0], 3'b000} +: 8];
        lane_h  = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (cur_ctrl[1:0])
            2'b01:   rd_ext = {{16{~cur_ctrl[2] & lane_h[15]}}, lane_h};
            2'b10:   rd_ext = {{24{~cur_ctrl[2] & lane_b[7]}}, lane_b};
            default: rd_ext = rd_word;
        endcase
    end

    // RAM is never cleared; a write commits only on the edge entering RESP
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && cur_we && in_range) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem[idx][8*k +: 8] <= wword[8*k +: 8];
            end
        end
    end

    // Response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            ready_q <= enter_resp;
            if (enter_resp && !cur_we) rdata_q <= in_range ? rd_ext : 32'h0;
        end
    end

    assign bus.MIO_ready = ready_q;
    assign bus.rdata     = rdata_q;

`ifdef MIO_BUS_ERR_EN
    logic berr_q;
    always_ff @(posedge clk) begin
        if (reset) berr_q <= 1'b0;
        else       berr_q <= enter_resp && !in_range;
    end
    assign bus.bus_err = berr_q;
`endif
endmodule

// File: tb/tb_mio_mem_responder.sv
// Scoreboarded bench for mio_mem_responder: one instance with 2 wait states, one with none.
`timescale 1ns/1ps
module tb_mio_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst2, rst0;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int pulses2 = 0;
    int pulses0 = 0;

    typedef struct {
        logic        rd;
        logic [31:0] data;
        int          cyc;
        logic        berr;
    } exp_t;

    exp_t q2[$];
    exp_t q0[$];
    exp_t e2, e0;

    mio_mem_responder_if b2();
    mio_mem_responder_if b0();

    mio_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .reset(rst2), .bus(b2)
    );
    mio_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
        .clk(clk), .reset(rst0), .bus(b0)
    );

    // Scoreboard for the 2-wait-state instance
    always @(negedge clk) begin
        if (b2.MIO_ready === 1'b1) begin
            pulses2++;
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL ready2_unexpected cyc=%0d got pulse required none", cyc);
            end else begin
                e2 = q2.pop_front();
                if (cyc != e2.cyc) begin
                    errors++;
                    $display("FAIL ready2_latency got cyc=%0d required cyc=%0d", cyc, e2.cyc);
                end
                if (e2.rd) begin
                    checks++;
                    if (b2.rdata !== e2.data) begin
                        errors++;
                        $display("FAIL rdata2 got=%h required=%h", b2.rdata, e2.data);
                    end
                end
`ifdef MIO_BUS_ERR_EN
                checks++;
                if (b2.bus_err !== e2.berr) begin
                    errors++;
                    $display("FAIL bus_err got=%b required=%b", b2.bus_err, e2.berr);
                end
`endif
            end
        end
    end

    // Scoreboard for the zero-wait-state instance
    always @(negedge clk) begin
        if (b0.MIO_ready === 1'b1) begin
            pulses0++;
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL ready0_unexpected cyc=%0d got pulse required none", cyc);
            end else begin
                e0 = q0.pop_front();
                if (cyc != e0.cyc) begin
                    errors++;
                    $display("FAIL ready0_latency got cyc=%0d required cyc=%0d", cyc, e0.cyc);
                end
                if (e0.rd) begin
                    checks++;
                    if (b0.rdata !== e0.data) begin
                        errors++;
                        $display("FAIL rdata0 got=%h required=%h", b0.rdata, e0.data);
                    end
                end
            end
        end
    end

    task automatic drive(input int which, input logic v, input logic we, input logic [2:0] ctrl,
                         input logic [31:0] a, input logic [31:0] wd);
        if (which == 2) begin
            b2.CPU_MIO = v; b2.mem_w = we; b2.RAMCtrl = ctrl; b2.addr = a; b2.wdata = wd;
        end else begin
            b0.CPU_MIO = v; b0.mem_w = we; b0.RAMCtrl = ctrl; b0.addr = a; b0.wdata = wd;
        end
    endtask

    // One transaction: drive for one cycle, queue the expectation, wait (bounded) for completion
    task automatic txn(input int which, input logic we, input logic [2:0] ctrl, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_be);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        drive(which, 1'b1, we, ctrl, a, wd);
        e.rd = !we; e.data = exp_d; e.berr = exp_be;
        if (which == 2) begin e.cyc = cyc + 3; q2.push_back(e); end
        else            begin e.cyc = cyc + 1; q0.push_back(e); end
        @(posedge clk); #1;
        drive(which, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        n = 0;
        while (((which == 2) ? q2.size() : q0.size()) != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL txn_timeout addr=%h pending=%0d required 0", a,
                     (which == 2) ? q2.size() : q0.size());
            if (which == 2) q2.delete(); else q0.delete();
        end
    endtask

    task automatic test_reset();
        rst2 = 1'b1; rst0 = 1'b1;
        drive(2, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 4;
        if (b2.MIO_ready !== 1'b0) begin errors++; $display("FAIL reset_ready2 got=%b required=0", b2.MIO_ready); end
        if (b2.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata2 got=%h required=0", b2.rdata); end
        if (b0.MIO_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0 got=%b required=0", b0.MIO_ready); end
        if (b0.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata0 got=%h required=0", b0.rdata); end
        @(posedge clk); #1;
        rst2 = 1'b0; rst0 = 1'b0;
    endtask

    task automatic test_word();
        txn(2, 1'b1, 3'b000, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        txn(2, 1'b0, 3'b000, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    endtask

    task automatic test_byte_lanes();
        txn(2, 1'b1, 3'b000, 32'h10, 32'h11223344, 32'h0, 1'b0);
        txn(2, 1'b0, 3'b010, 32'h13, 32'h0, 32'h00000011, 1'b0);
        txn(2, 1'b1, 3'b010, 32'h11, 32'h000000F0, 32'h0, 1'b0);
        txn(2, 1'b0, 3'b010, 32'h11, 32'h0, 32'hFFFFFFF0, 1'b0);
        txn(2, 1'b0, 3'b110, 32'h11, 32'h0, 32'h000000F0, 1'b0);
        txn(2, 1'b0, 3'b000, 32'h10, 32'h0, 32'h1122F044, 1'b0);
    endtask

    task automatic test_halfword();
        txn(2, 1'b1, 3'b000, 32'h20, 32'h80017FFE, 32'h0, 1'b0);
        txn(2, 1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 1'b0);
        txn(2, 1'b0, 3'b101, 32'h22, 32'h0, 32'h00008001, 1'b0);
        txn(2, 1'b0, 3'b001, 32'h21, 32'h0, 32'h00007FFE, 1'b0);
        txn(2, 1'b0, 3'b011, 32'h20, 32'h0, 32'h80017FFE, 1'b0);
    endtask

    task automatic test_random_lanes();
        logic [31:0] mdl [4];
        logic [31:0] d, ex;
        logic [2:0]  ctrl;
        int          i, lane, sz;
        for (int k = 0; k < 4; k++) begin
            mdl[k] = $urandom;
            txn(2, 1'b1, 3'b000, 32'h100 + 32'(4*k), mdl[k], 32'h0, 1'b0);
        end
        for (int n = 0; n < 10; n++) begin
            i = $urandom_range(0, 3); lane = $urandom_range(0, 3); sz = $urandom_range(0, 2);
            d = $urandom;
            if (sz == 2) begin mdl[i][8*lane +: 8] = d[7:0]; ctrl = 3'b010; end
            else if (sz == 1) begin mdl[i][16*(lane/2) +: 16] = d[15:0]; ctrl = 3'b001; end
            else begin mdl[i] = d; ctrl = 3'b000; end
            txn(2, 1'b1, ctrl, 32'h100 + 32'(4*i + lane), d, 32'h0, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            txn(2, 1'b0, 3'b000, 32'h100 + 32'(4*k), 32'h0, mdl[k], 1'b0);
            lane = $urandom_range(0, 3);
            d  = mdl[k];
            ex = {{24{d[8*lane+7]}}, d[8*lane +: 8]};
            txn(2, 1'b0, 3'b010, 32'h100 + 32'(4*k + lane), 32'h0, ex, 1'b0);
        end
    endtask

`ifdef MIO_BUS_ERR_EN
    task automatic test_bus_err();
        txn(2, 1'b1, 3'b000, 32'h0, 32'h55AA55AA, 32'h0, 1'b0);
        txn(2, 1'b0, 3'b000, 32'h1000, 32'h0, 32'h0, 1'b1);
        txn(2, 1'b1, 3'b000, 32'h1000, 32'h12345678, 32'h0, 1'b1);
        txn(2, 1'b0, 3'b000, 32'h0, 32'h0, 32'h55AA55AA, 1'b0);
    endtask
`else
    task automatic test_wrap();
        txn(2, 1'b1, 3'b000, 32'h1004, 32'h600DF00D, 32'h0, 1'b0);
        txn(2, 1'b0, 3'b000, 32'h4, 32'h0, 32'h600DF00D, 1'b0);
        txn(2, 1'b0, 3'b000, 32'h2004, 32'h0, 32'h600DF00D, 1'b0);
    endtask
`endif

    task automatic test_back_to_back();
        exp_t e;
        int   p;
        txn(0, 1'b1, 3'b000, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0);
        txn(0, 1'b1, 3'b000, 32'h44, 32'h0BADBEEF, 32'h0, 1'b0);
        p = pulses0;
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 3'b000, 32'h40, 32'h0);
        e.rd = 1'b1; e.data = 32'hCAFEF00D; e.berr = 1'b0; e.cyc = cyc + 1;
        q0.push_back(e);
        @(posedge clk); #1;
        b0.addr = 32'h44;
        e.data = 32'h0BADBEEF; e.cyc = cyc + 2;
        q0.push_back(e);
        @(posedge clk); #1;
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (4) @(negedge clk);
        checks += 2;
        if (pulses0 - p != 2) begin errors++; $display("FAIL b2b_pulses got=%0d required=2", pulses0 - p); end
        if (q0.size() != 0) begin errors++; $display("FAIL b2b_pending got=%0d required=0", q0.size()); q0.delete(); end
    endtask

    task automatic test_reset_in_wait();
        int p;
        txn(2, 1'b1, 3'b000, 32'h30, 32'h01234567, 32'h0, 1'b0);
        txn(2, 1'b0, 3'b000, 32'h30, 32'h0, 32'h01234567, 1'b0);
        p = pulses2;
        @(posedge clk); #1;
        drive(2, 1'b1, 1'b1, 3'b000, 32'h30, 32'hA5A5A5A5);
        @(posedge clk); #1;
        drive(2, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        rst2 = 1'b1;
        @(posedge clk); #1;
        rst2 = 1'b0;
        repeat (6) @(negedge clk);
        checks += 2;
        if (pulses2 != p) begin errors++; $display("FAIL rstwait_pulse got=%0d required=0", pulses2 - p); end
        if (b2.rdata !== 32'h0) begin errors++; $display("FAIL rstwait_rdata got=%h required=0", b2.rdata); end
        txn(2, 1'b0, 3'b000, 32'h30, 32'h0, 32'h01234567, 1'b0);
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_lanes();
        test_halfword();
        test_random_lanes();
`ifdef MIO_BUS_ERR_EN
        test_bus_err();
`else
        test_wrap();
`endif
        test_back_to_back();
        test_reset_in_wait();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
